// File: rtl/present_pkg.sv
// Shared types and constants for the box-nesting solver feeder.
package present_pkg;

   localparam int WORD_W = 32;
   localparam int N_DEF  = 100;

   typedef enum logic [1:0] {IDLE, PRESENT_HOLD, SETTLE, DONE} state_t;

   // Settle time long enough for an N-deep solver to converge.
   function automatic int settle_of(input int n);
      return n * n + n;
   endfunction

   localparam int SETTLE_DEF = N_DEF * N_DEF + N_DEF;

endpackage

// File: rtl/box_feeder_timer.sv
// Loadable down-counter; expire flags the final cycle of a loaded interval.
module box_feeder_timer
   import present_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WORD_W-1:0] value,
   output logic              expire
);

   logic [WORD_W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)              count <= '0;
      else if (load)         count <= value;
      else if (count != '0)  count <= count - WORD_W'(1);
   end

   assign expire = (count == WORD_W'(1));

endmodule

// File: rtl/box_feeder.sv
// Stream-to-PIO feeder: presents each useful box to the solver, holds it,
// then waits for the solver to settle before flagging done.
module box_feeder
   import present_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int HOLD   = 2,
   parameter int SETTLE = settle_of(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_width,
   input  logic [WORD_W-1:0] in_height,
   input  logic              in_last,
   output logic [WORD_W-1:0] width,
   output logic [WORD_W-1:0] height,
   output logic [WORD_W-1:0] avail,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [7:0]        sent
);

   localparam logic [WORD_W-1:0] HOLD_W   = WORD_W'(HOLD);
   localparam logic [WORD_W-1:0] SETTLE_W = WORD_W'(SETTLE);
   localparam logic [WORD_W-1:0] N_W      = WORD_W'(N);

   state_t            state, nxt_state;
   logic              avail_q, last_q;
   logic              accept, new_frame, drop, keep;
   logic [7:0]        sent_eff;
   logic              tmr_load, tmr_expire;
   logic [WORD_W-1:0] tmr_value;

   assign in_ready  = (state == present_pkg::IDLE) || (state == present_pkg::DONE);
   assign accept    = in_valid & in_ready;
   assign new_frame = accept & (state == present_pkg::DONE);
   // The solver only latches on a change, so a repeat of the presented pair is useless.
   assign drop      = (in_width == '0) || (in_height == '0) ||
                      ((in_width == width) && (in_height == height));
   assign keep      = accept & ~drop;
   assign sent_eff  = new_frame ? 8'd0 : sent;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= present_pkg::IDLE;
      else      state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      tmr_load  = 1'b0;
      tmr_value = HOLD_W;
      case (state)
         present_pkg::IDLE, present_pkg::DONE: begin
            if (accept) begin
               if (!drop) begin
                  nxt_state = present_pkg::PRESENT_HOLD;
                  tmr_load  = 1'b1;
               end else if (in_last) begin
                  if (sent_eff != 8'd0) begin
                     nxt_state = present_pkg::SETTLE;
                     tmr_load  = 1'b1;
                     tmr_value = SETTLE_W;
                  end else begin
                     nxt_state = present_pkg::DONE;
                  end
               end else begin
                  nxt_state = present_pkg::IDLE;
               end
            end
         end
         present_pkg::PRESENT_HOLD: begin
            if (tmr_expire) begin
               if (last_q) begin
                  nxt_state = present_pkg::SETTLE;
                  tmr_load  = 1'b1;
                  tmr_value = SETTLE_W;
               end else begin
                  nxt_state = present_pkg::IDLE;
               end
            end
         end
         present_pkg::SETTLE: begin
            if (tmr_expire) nxt_state = present_pkg::DONE;
         end
      endcase
   end

   // Later assignments win, so a kept box on a new frame counts from zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         width    <= '0;
         height   <= '0;
         avail_q  <= 1'b0;
         last_q   <= 1'b0;
         sent     <= 8'd0;
         overflow <= 1'b0;
      end else begin
         if (accept) last_q <= in_last;
         if (new_frame) begin
            sent     <= 8'd0;
            overflow <= 1'b0;
         end
         if (keep) begin
            width   <= in_width;
            height  <= in_height;
            avail_q <= 1'b1;
            sent    <= (sent_eff == 8'hFF) ? sent_eff : sent_eff + 8'd1;
            if ({{(WORD_W-8){1'b0}}, sent_eff} == N_W) overflow <= 1'b1;
         end
      end
   end

   box_feeder_timer u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (tmr_load),
      .value  (tmr_value),
      .expire (tmr_expire)
   );

   assign avail = {{(WORD_W-1){1'b0}}, avail_q};
   assign busy  = (state == present_pkg::PRESENT_HOLD) || (state == present_pkg::SETTLE);
   assign done  = (state == present_pkg::DONE);

endmodule

// File: tb/tb_box_feeder.sv
// Bench for box_feeder: timestamp-based reference model plus directed frames.
module tb_box_feeder;

   localparam int N      = 4;
   localparam int HOLD   = 2;
   localparam int SETTLE = 10;

   logic        clk = 1'b0, rst = 1'b0;
   logic        in_valid = 1'b0, in_last = 1'b0;
   logic [31:0] in_width = '0, in_height = '0;
   logic        in_ready, busy, done, overflow;
   logic [31:0] width, height, avail;
   logic [7:0]  sent;

   int checks = 0, errors = 0, cyc = 0, k = 0;
   bit run = 1'b0;

   // Model: outputs as plain values, readiness/done as absolute cycle times.
   logic [31:0] m_w, m_h;
   logic        m_avail, m_ovf, m_done_pend;
   int          m_sent, m_ready_at, m_done_at;

   box_feeder #(.N(N), .HOLD(HOLD), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_width(in_width), .in_height(in_height), .in_last(in_last),
      .width(width), .height(height), .avail(avail), .busy(busy),
      .done(done), .overflow(overflow), .sent(sent)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_w = '0; m_h = '0; m_avail = 1'b0; m_ovf = 1'b0; m_done_pend = 1'b0;
      m_sent = 0; m_ready_at = 0; m_done_at = 0;
   endtask

   // Box accepted at the edge after which cyc == t.
   task automatic model_accept(input logic [31:0] w, input logic [31:0] h, input logic last, input int t);
      if (m_done_pend && (t - 1) >= m_done_at) begin
         m_sent = 0; m_ovf = 1'b0; m_done_pend = 1'b0;
      end
      if (w == 0 || h == 0 || (w == m_w && h == m_h)) begin
         if (last) begin
            m_done_pend = 1'b1;
            m_done_at   = (m_sent > 0) ? t + SETTLE : t;
            m_ready_at  = m_done_at;
         end
      end else begin
         if (m_sent == N) m_ovf = 1'b1;
         if (m_sent < 255) m_sent++;
         m_w = w; m_h = h; m_avail = 1'b1;
         m_ready_at = t + HOLD;
         if (last) begin
            m_done_pend = 1'b1;
            m_done_at   = t + HOLD + SETTLE;
            m_ready_at  = m_done_at;
         end
      end
   endtask

   always @(negedge clk) begin
      if (run && rst) begin
         chk("in_ready", 32'(in_ready), 32'(cyc >= m_ready_at));
         chk("busy",     32'(busy),     32'(cyc < m_ready_at));
         chk("done",     32'(done),     32'(m_done_pend && cyc >= m_done_at));
         chk("width",    width,         m_w);
         chk("height",   height,        m_h);
         chk("avail",    avail,         32'(m_avail));
         chk("sent",     32'(sent),     32'(m_sent));
         chk("overflow", 32'(overflow), 32'(m_ovf));
      end
   end

   // Returns one time unit after the accepting edge.
   task automatic send(input logic [31:0] w, input logic [31:0] h, input logic last);
      int  guard;
      bit  acc;
      guard = 0;
      @(negedge clk);
      in_valid = 1'b1; in_width = w; in_height = h; in_last = last;
      forever begin
         acc = (cyc >= m_ready_at);
         @(posedge clk); #1;
         if (acc) begin
            model_accept(w, h, last, cyc);
            break;
         end
         guard++;
         if (guard > 200) begin
            checks++; errors++;
            $display("FAIL send_timeout: box %0d,%0d never accepted", w, h);
            break;
         end
         @(negedge clk);
      end
      in_valid = 1'b0; in_width = '0; in_height = '0; in_last = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_width"},    width,          32'd0);
      chk({tag, "_height"},   height,         32'd0);
      chk({tag, "_avail"},    avail,          32'd0);
      chk({tag, "_busy"},     32'(busy),      32'd0);
      chk({tag, "_done"},     32'(done),      32'd0);
      chk({tag, "_overflow"}, 32'(overflow),  32'd0);
      chk({tag, "_sent"},     32'(sent),      32'd0);
      chk({tag, "_in_ready"}, 32'(in_ready),  32'd1);
   endtask

   initial begin
      model_reset();
      #12;
      check_reset_vals("reset");
      @(negedge clk); rst = 1'b1; run = 1'b1;

      // Zero-sized boxes only: nothing presented, done straight away.
      send(32'd0, 32'd9, 1'b0);
      send(32'd9, 32'd0, 1'b1);
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_avail", avail, 32'd0);
      idle(2);

      // Single box with last.
      send(32'd5, 32'd7, 1'b1);
      k = cyc;
      chk("single_width", width, 32'd5);
      chk("single_height", height, 32'd7);
      chk("single_avail", avail, 32'd1);
      wait_cyc(k + 11);
      chk("single_done_early", 32'(done), 32'd0);
      wait_cyc(k + 12);
      chk("single_done", 32'(done), 32'd1);
      chk("single_sent", 32'(sent), 32'd1);

      // Duplicate in the middle of a stream.
      send(32'd3, 32'd3, 1'b0);
      send(32'd3, 32'd3, 1'b0);
      chk("dup_width", width, 32'd3);
      send(32'd4, 32'd1, 1'b1);
      chk("dup_width2", width, 32'd4);
      chk("dup_height2", height, 32'd1);
      idle(14);
      chk("dup_sent", 32'(sent), 32'd2);

      // Overflow past N boxes.
      for (int i = 1; i <= 6; i++) begin
         send(32'd1, 32'(i), i == 6);
         if (i == 4) chk("ovf_before", 32'(overflow), 32'd0);
         if (i == 5) chk("ovf_set", 32'(overflow), 32'd1);
      end
      chk("ovf_sent", 32'(sent), 32'd6);
      idle(14);
      send(32'd2, 32'd1, 1'b0);
      chk("ovf_cleared", 32'(overflow), 32'd0);
      chk("ovf_new_sent", 32'(sent), 32'd1);
      send(32'd2, 32'd9, 1'b1);
      idle(14);

      // Reset during hold.
      send(32'd7, 32'd7, 1'b0);
      #2 rst = 1'b0; model_reset();
      #1 check_reset_vals("rst_hold");
      @(negedge clk); #1 rst = 1'b1;
      send(32'd2, 32'd2, 1'b1);
      chk("post_rst_width", width, 32'd2);
      chk("post_rst_avail", avail, 32'd1);

      // Reset during settle.
      idle(5);
      #2 rst = 1'b0; model_reset();
      #1 check_reset_vals("rst_settle");
      @(negedge clk); #1 rst = 1'b1;
      send(32'd2, 32'd2, 1'b0);
      chk("post_rst2_width", width, 32'd2);
      idle(3);

      // Back-to-back frames; frame 2 opens with frame 1's last box.
      send(32'd8, 32'd9, 1'b1);
      idle(14);
      chk("b2b_done1", 32'(done), 32'd1);
      send(32'd8, 32'd9, 1'b0);
      chk("b2b_done_clr", 32'(done), 32'd0);
      chk("b2b_sent_clr", 32'(sent), 32'd0);
      send(32'd6, 32'd6, 1'b1);
      k = cyc;
      wait_cyc(k + 11);
      chk("b2b_done_early", 32'(done), 32'd0);
      wait_cyc(k + 12);
      chk("b2b_done", 32'(done), 32'd1);
      chk("b2b_sent", 32'(sent), 32'd1);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/box_feeder.md
# box_feeder

Stream-to-PIO transmitter that drives the width/height/avail interface consumed by the box-nesting solver. A valid/ready stream of box sizes goes in. Each box is presented on the solver's `width`/`height` inputs and held for a fixed dwell. Boxes the solver would ignore or treat as empty are dropped. After the last box of a frame, the block waits a settle interval and then flags `done`, so software knows the solver's answer has converged.

## Interface
Parameters:
- `N`, 100: solver depth (maximum boxes per frame).
- `HOLD`, 2: cycles `in_ready` stays low after each presented box, ≥1.
- `SETTLE`, N*N+N: cycles from the last presented box to `done`, ≥1.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: input box available.
- `in_ready`, out, 1: feeder accepts a box this cycle.
- `in_width`, in, 32: box width, unsigned.
- `in_height`, in, 32: box height, unsigned.
- `in_last`, in, 1: this box ends the frame.
- `width`, out, 32: to the solver's width PIO.
- `height`, out, 32: to the solver's height PIO.
- `avail`, out, 32: bit 0 is the presented-data-valid flag; bits 31:1 are always 0.
- `busy`, out, 1: frame in progress (states PRESENT_HOLD or SETTLE).
- `done`, out, 1: frame settled; the solver's answer is final.
- `overflow`, out, 1: sticky; more than N boxes were presented in the current frame.
- `sent`, out, 8: boxes presented in the current frame, saturating at 255.

## Operation
- States: IDLE, PRESENT_HOLD, SETTLE, DONE.
- `in_ready` = 1 in IDLE and DONE, 0 otherwise. Accept = `in_valid` & `in_ready` at a rising edge.
- Drop rule: an accepted box is dropped if `in_width`==0, or `in_height`==0, or (`in_width`,`in_height`) equals the currently presented (`width`,`height`) pair.
  - The duplicate check uses the presented pair, not the frame, and applies across frames, because the solver only latches on a change.
  - A dropped box changes no output except via `in_last` handling.
- IDLE:
  - Accepted, kept box: register it onto `width`/`height`, set `avail[0]`=1, increment `sent`, load the timer with HOLD, go to PRESENT_HOLD. Record `in_last`.
  - Accepted, dropped box with `in_last`=1: go to SETTLE if `sent`>0, otherwise to DONE.
  - Accepted, dropped box with `in_last`=0: stay in IDLE.
- PRESENT_HOLD: the timer counts down. When it expires, go to SETTLE (timer loaded with SETTLE) if the recorded last flag is set, otherwise go to IDLE.
- SETTLE: the timer counts down. When it expires, go to DONE.
- DONE:
  - `done`=1.
  - The next accept starts a new frame: clear `done`, `sent` and `overflow`, then process the box exactly as in IDLE.
- Overflow: a kept box presented while `sent`==N still gets presented, and sets `overflow`.
- `avail[0]` goes high with the first presented box and is cleared only by `rst`. `width`/`height` hold their last value indefinitely.

## Timing
- Reset (`rst`=0, asynchronous) sets:
  - `width`=0, `height`=0, `avail`=0.
  - `busy`=0, `done`=0, `overflow`=0, `sent`=0.
  - State IDLE, so `in_ready`=1 combinationally.
- Presentation latency: a box accepted at edge k appears on `width`/`height`/`avail` immediately after edge k.
- Hold: `in_ready` is low from edge k until edge k+HOLD. The next accept can occur at edge k+HOLD+1 at the earliest.
- Done latency: with the last box kept at edge k, `done` rises after edge k+HOLD+SETTLE.
- Dropped `in_last` with `sent`>0 at edge k: `done` rises after edge k+SETTLE.
- Dropped `in_last` with `sent`==0 at edge k: `done` rises after edge k.
- Reset mid-frame (any state): outputs return to their reset values immediately. The stream handshake restarts at the first edge after `rst` is released.
- `in_valid` held high while `in_ready`=0 has no effect. Input fields are sampled only at an accept.

## Structure
- Shared package `present_pkg`:
  - `WORD_W`=32.
  - State enum {IDLE, PRESENT_HOLD, SETTLE, DONE}.
  - Default N and the SETTLE formula constant.
- Sub-module `box_feeder_timer`: a loadable down-counter shared by HOLD and SETTLE.
  - Inputs `load`, `value[31:0]`.
  - Output `expire` pulses in the cycle the count reaches 1.

## Test plan
- Single box (5,7) with `in_last`, HOLD=2, SETTLE=10 → `width`=5, `height`=7, `avail`=1 after the accept edge; `in_ready` low for 2 cycles; `done`=1 after 12 edges; `sent`=1.
- Stream (3,3), (3,3), (4,1) → second box dropped; `sent`=2; `width`/`height` sequence 3,3 then 4,1; no presentation cycle for the duplicate.
- Boxes (0,9) and (9,0), the latter with `in_last`, as the first frame after reset → both dropped; `done` is 1 the cycle after the second accept; `avail`=0; `busy` never asserted.
- N=4, six distinct boxes → `overflow` rises on the 5th presentation; `sent`=6. The next frame's first accept clears `overflow` and sets `sent`=1.
- `rst` asserted during PRESENT_HOLD and during SETTLE → all outputs reach reset values without a clock edge; `in_ready`=1; a subsequent box (2,2) is presented normally.
- Back-to-back frames, frame 2 starting with the box that ended frame 1 → that box is dropped; `done` clears on the accept; frame 2 timing matches the single-frame case.
